// File: rtl/gpio_cfg_defs.sv
`timescale 1ns/1ps
// gpio_cfg_defs
// Shared definitions for the GPIO pad-control configuration path: the
// sequencer FSM state encoding and the default pad-control word width and
// reset value. gpio_control_block uses the same width and default value.
// No ports (package).
package gpio_cfg_defs;

   localparam int unsigned DEF_PAD_CTRL_BITS = 12;
   localparam logic [11:0] DEF_GPIO_DEFAULTS = 12'hC00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/gpio_cfg_regfile.sv
`timescale 1ns/1ps
// gpio_cfg_regfile
// One configuration word per GPIO, all reset to GPIO_DEFAULTS.
// Ports:
//   serial_clock, resetn : clock, async active-low reset
//   wr_req, wr_lock      : write strobe; writes are dropped while wr_lock=1
//   wr_addr, wdata       : write index / data (out-of-range index is dropped)
//   rd_addr, rdata       : combinational readback, 0 for out-of-range index
//   seq_idx, seq_word    : sequencer read port (index always in range)
module gpio_cfg_regfile
   import gpio_cfg_defs::*;
#(
   parameter int NUM_GPIO = 19,
   parameter int PAD_CTRL_BITS = DEF_PAD_CTRL_BITS,
   parameter logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULTS = DEF_GPIO_DEFAULTS
) (
   input  logic                          serial_clock,
   input  logic                          resetn,
   input  logic                          wr_req,
   input  logic                          wr_lock,
   input  logic [$clog2(NUM_GPIO)-1:0]   wr_addr,
   input  logic [PAD_CTRL_BITS-1:0]      wdata,
   input  logic [$clog2(NUM_GPIO)-1:0]   rd_addr,
   output logic [PAD_CTRL_BITS-1:0]      rdata,
   input  logic [$clog2(NUM_GPIO)-1:0]   seq_idx,
   output logic [PAD_CTRL_BITS-1:0]      seq_word
);

   logic [PAD_CTRL_BITS-1:0] words [NUM_GPIO];
   logic                     wr_ok;

   assign wr_ok = wr_req && !wr_lock && (int'(wr_addr) < NUM_GPIO);

   always_ff @(posedge serial_clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_GPIO; i++) words[i] <= GPIO_DEFAULTS;
      end else if (wr_ok) begin
         words[wr_addr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (int'(rd_addr) < NUM_GPIO) rdata = words[rd_addr];
   end

   // A write in the same cycle a transfer starts must already be visible to
   // the sequencer, so the pending write data is forwarded on a match.
   always_comb begin
      seq_word = words[seq_idx];
      if (wr_ok && (wr_addr == seq_idx)) seq_word = wdata;
   end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
`timescale 1ns/1ps
// gpio_cfg_sequencer
// Shifts NUM_GPIO configuration words MSB-first (last word first) down the
// gpio_control_block daisy chain, then pulses the chain load strobe.
// Ports:
//   serial_clock, resetn          : clock, async active-low reset
//   cfg_wr, cfg_addr, cfg_wdata   : config word write (ignored while busy)
//   cfg_rdata                     : combinational readback of word[cfg_addr]
//   xfer_start                    : one-cycle request to shift and load
//   busy, done                    : busy in SHIFT/LOAD, one-cycle done pulse
//   chain_clock, chain_data,
//   chain_load                    : registered drive to the head of the chain
//   fsm_state                     : current sequencer state (observation)
// Handshake: xfer_start is a request sampled on a rising edge; it is accepted
// only when busy=0 (IDLE or DONE) and never queued. busy rises on the edge
// that accepts it and done pulses for one cycle when the load has finished.
module gpio_cfg_sequencer
   import gpio_cfg_defs::*;
#(
   parameter int NUM_GPIO = 19,
   parameter int PAD_CTRL_BITS = DEF_PAD_CTRL_BITS,
   parameter logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULTS = DEF_GPIO_DEFAULTS,
   parameter bit AUTO_LOAD = 1'b1
) (
   input  logic                          serial_clock,
   input  logic                          resetn,
   input  logic                          cfg_wr,
   input  logic [$clog2(NUM_GPIO)-1:0]   cfg_addr,
   input  logic [PAD_CTRL_BITS-1:0]      cfg_wdata,
   output logic [PAD_CTRL_BITS-1:0]      cfg_rdata,
   input  logic                          xfer_start,
   output logic                          busy,
   output logic                          done,
   output logic                          chain_clock,
   output logic                          chain_data,
   output logic                          chain_load,
   output seq_state_t                    fsm_state
);

   localparam int AW = $clog2(NUM_GPIO);
   localparam int BW = $clog2(PAD_CTRL_BITS);
   localparam logic [AW-1:0] LAST_WORD = AW'(NUM_GPIO - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(PAD_CTRL_BITS - 1);

   seq_state_t              state_q, state_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [AW-1:0]           word_idx_q, word_idx_d;
   logic                    phase_q, phase_d;
   logic                    auto_q;
   logic                    chain_clock_d, chain_data_d, chain_load_d;
   logic                    load_bit;
   logic                    start_req;
   logic [PAD_CTRL_BITS-1:0] seq_word;

   gpio_cfg_regfile #(
      .NUM_GPIO      (NUM_GPIO),
      .PAD_CTRL_BITS (PAD_CTRL_BITS),
      .GPIO_DEFAULTS (GPIO_DEFAULTS)
   ) u_regfile (
      .serial_clock (serial_clock),
      .resetn       (resetn),
      .wr_req       (cfg_wr),
      .wr_lock      (busy),
      .wr_addr      (cfg_addr),
      .wdata        (cfg_wdata),
      .rd_addr      (cfg_addr),
      .rdata        (cfg_rdata),
      .seq_idx      (word_idx_d),
      .seq_word     (seq_word)
   );

   // High only during the first cycle after reset release.
   always_ff @(posedge serial_clock or negedge resetn) begin
      if (!resetn) auto_q <= AUTO_LOAD;
      else         auto_q <= 1'b0;
   end

   assign start_req = xfer_start || auto_q;

   always_ff @(posedge serial_clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         word_idx_q  <= '0;
         phase_q     <= 1'b0;
         chain_clock <= 1'b0;
         chain_data  <= 1'b0;
         chain_load  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         word_idx_q  <= word_idx_d;
         phase_q     <= phase_d;
         chain_clock <= chain_clock_d;
         chain_data  <= chain_data_d;
         chain_load  <= chain_load_d;
      end
   end

   // In SHIFT, phase 0 presents a new bit with the chain clock low and
   // phase 1 raises the chain clock with the bit held, so each chain rising
   // edge has a full serial_clock cycle of setup and of hold. In LOAD the
   // phase bit counts the two strobe cycles.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      word_idx_d    = word_idx_q;
      phase_d       = phase_q;
      chain_clock_d = 1'b0;
      chain_data_d  = 1'b0;
      chain_load_d  = 1'b0;
      load_bit      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_req) begin
               state_d    = ST_SHIFT;
               bit_cnt_d  = LAST_BIT;
               word_idx_d = LAST_WORD;
               phase_d    = 1'b0;
               load_bit   = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (!phase_q) begin
               phase_d       = 1'b1;
               chain_clock_d = 1'b1;
               chain_data_d  = chain_data;
            end else if ((bit_cnt_q == '0) && (word_idx_q == '0)) begin
               state_d      = ST_LOAD;
               phase_d      = 1'b0;
               chain_load_d = 1'b1;
            end else begin
               phase_d  = 1'b0;
               load_bit = 1'b1;
               if (bit_cnt_q == '0) begin
                  bit_cnt_d  = LAST_BIT;
                  word_idx_d = word_idx_q - 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (!phase_q) begin
               phase_d      = 1'b1;
               chain_load_d = 1'b1;
            end else begin
               state_d = ST_DONE;
               phase_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load_bit) chain_data_d = seq_word[bit_cnt_d];
   end

   assign busy      = (state_q == ST_SHIFT) || (state_q == ST_LOAD);
   assign done      = (state_q == ST_DONE);
   assign fsm_state = state_q;

endmodule
